// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states,
// latency bounds and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;
  localparam int CNT_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Loads reject 011/110/111; stores only allow B/H/W.
  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_W);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return (a != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus the word-wide data RAM bus.
// master = core + RAM side, slave = the load/store unit.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  logic [31:0] ram_address;
  logic [31:0] data_in_ram;
  logic [31:0] data_out_ram;
  logic        ram_enable_write;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, data_in_ram,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
           ram_address, data_out_ram, ram_enable_write
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, data_in_ram,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
           ram_address, data_out_ram, ram_enable_write
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: little-endian load extraction/extension and
// sub-word store merge into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [4:0]  w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = {i_lane, 3'b000};
  assign w_byte  = i_word[w_shift +: 8];
  assign w_half  = i_lane[1] ? i_word[31:16] : i_word[15:0];

  // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load = {24'h0, w_byte};
      F3_HU:   o_load = {16'h0, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_store = i_word;
    case (i_funct3)
      F3_B: o_store[w_shift +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_lane[1]) o_store[31:16] = i_wdata[15:0];
        else           o_store[15:0]  = i_wdata[15:0];
      end
      F3_W:    o_store = i_wdata;
      default: o_store = i_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, word-only RAM traffic, RMW for SB/SH.
// Define LSU_MISALIGN_TRAP_EN to send misaligned H/HU/SH/W/SW down the error path.
module lsu
  import lsu_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  if (RAM_LATENCY < LAT_MIN || RAM_LATENCY > LAT_MAX) begin : g_lat_chk
    $fatal(1, "lsu: RAM_LATENCY out of range 1..4");
  end

  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(RAM_LATENCY - 1);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [2:0]       r_f3;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [4:0]       r_rd;
  logic             r_err;
  logic [31:0]      r_word;

  logic             w_accept;
  logic             w_misalign;
  logic             w_err;
  logic             w_read_done;
  logic [31:0]      w_load;
  logic [31:0]      w_store;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept    = bus.req_valid && (r_state == ST_IDLE);
  assign w_err       = is_illegal(bus.req_we, bus.req_funct3) || w_misalign;
  assign w_read_done = (r_state == ST_READ) && (r_cnt == CNT_END);

  lsu_align u_align (
    .i_word   (r_word),
    .i_lane   (r_addr[1:0]),
    .i_funct3 (r_f3),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_store  (w_store)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
      r_word  <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_we    <= bus.req_we;
      r_f3    <= bus.req_funct3;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_rd    <= bus.req_rd;
      r_err   <= w_err;
      r_word  <= '0;
    end else if (r_state == ST_READ) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_read_done) r_word <= bus.data_in_ram;
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    w_next               = r_state;
    bus.req_ready        = 1'b0;
    bus.rsp_valid        = 1'b0;
    bus.rsp_rdata        = '0;
    bus.rsp_rd           = '0;
    bus.rsp_err          = 1'b0;
    bus.ram_address      = {2'b00, r_addr[31:2]};
    bus.data_out_ram     = '0;
    bus.ram_enable_write = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) begin
          if (w_err)                         w_next = ST_RESP;
          else if (!bus.req_we)              w_next = ST_READ;
          else if (bus.req_funct3 == F3_W)   w_next = ST_WRITE;
          else                               w_next = ST_READ;
        end
      end
      ST_READ: begin
        if (w_read_done) w_next = r_we ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        bus.data_out_ram     = w_store;
        bus.ram_enable_write = 1'b1;
        w_next               = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rd    = r_rd;
        bus.rsp_err   = r_err;
        if (!r_we && !r_err) bus.rsp_rdata = w_load;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with RAM_LATENCY=2: scoreboarded responses, strobe
// timing, RMW contents and mid-operation reset.
module tb_lsu;
  import lsu_pkg::*;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
    int          lat;
    int          strobe_cyc;
    logic [31:0] strobe_data;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    total = 0;
  int    bad = 0;
  exp_t  sb_q[$];

  logic [31:0] mem [0:255];
  logic        r_loaded = 1'b0;
  logic [31:0] r_ram_a = '0;

  lsu_if bus ();

  lsu #(.RAM_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: data_in_ram reflects the address seen LAT-1 cycles earlier.
  always @(posedge clk) begin
    if (!r_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'h8899AABB;
      r_loaded   <= 1'b1;
    end else if (bus.ram_enable_write) begin
      mem[bus.ram_address[7:0]] <= bus.data_out_ram;
    end
    r_ram_a <= bus.ram_address;
  end
  assign bus.data_in_ram = mem[r_ram_a[7:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input int exp_strobe, input logic [31:0] exp_sdata);
    exp_t e;
    int   n;
    logic got;
    int   strobe_cyc;
    logic [31:0] sdata;
    @(negedge clk);
    check({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    sb_q.push_back('{exp_rdata, rd, exp_err, exp_lat, exp_strobe, exp_sdata});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    got = 1'b0;
    strobe_cyc = -1;
    sdata = '0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.ram_enable_write) begin
        strobe_cyc = n;
        sdata = bus.data_out_ram;
      end
      if (bus.rsp_valid) begin
        got = 1'b1;
        e = sb_q.pop_front();
        check({tag, "_lat"}, n, e.lat);
        check({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        check({tag, "_rd"}, {27'h0, bus.rsp_rd}, {27'h0, e.rd});
        check({tag, "_err"}, {31'h0, bus.rsp_err}, {31'h0, e.err});
        check({tag, "_strobe_cyc"}, strobe_cyc, e.strobe_cyc);
        if (e.strobe_cyc > 0) check({tag, "_strobe_data"}, sdata, e.strobe_data);
      end else if (!exp_err) begin
        check({tag, "_addr"}, bus.ram_address, {2'b00, addr[31:2]});
      end
    end
    check({tag, "_got_rsp"}, {31'h0, got}, 32'h1);
    @(negedge clk);
    check({tag, "_pulse"}, {31'h0, bus.rsp_valid}, 32'h0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_rd     = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    check("rst_we", {31'h0, bus.ram_enable_write}, 32'h0);
    check("rst_addr", bus.ram_address, 32'h0);
    check("rst_dout", bus.data_out_ram, 32'h0);
    rst_n = 1'b1;

    run_req("lb",  1'b0, F3_B,  32'h103, 32'h0, 5'd5,  32'hFFFFFF88, 1'b0, LAT + 1, -1, 32'h0);
    run_req("lbu", 1'b0, F3_BU, 32'h103, 32'h0, 5'd6,  32'h00000088, 1'b0, LAT + 1, -1, 32'h0);
    run_req("lhu", 1'b0, F3_HU, 32'h102, 32'h0, 5'd7,  32'h00008899, 1'b0, LAT + 1, -1, 32'h0);
    run_req("lh",  1'b0, F3_H,  32'h100, 32'h0, 5'd8,  32'hFFFFAABB, 1'b0, LAT + 1, -1, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    run_req("lw_mis", 1'b0, F3_W, 32'h102, 32'h0, 5'd9, 32'h0, 1'b1, 1, -1, 32'h0);
    run_req("sh_mis", 1'b1, F3_H, 32'h101, 32'hBEEF, 5'd9, 32'h0, 1'b1, 1, -1, 32'h0);
`else
    run_req("lw_mis", 1'b0, F3_W, 32'h102, 32'h0, 5'd9, 32'h8899AABB, 1'b0, LAT + 1, -1, 32'h0);
`endif
    run_req("sb",  1'b1, F3_B,  32'h101, 32'h12, 5'd10, 32'h0, 1'b0, LAT + 2, LAT + 1, 32'h889912BB);
    run_req("lw1", 1'b0, F3_W,  32'h100, 32'h0, 5'd11, 32'h889912BB, 1'b0, LAT + 1, -1, 32'h0);
    run_req("sh",  1'b1, F3_H,  32'h102, 32'h1234CAFE, 5'd12, 32'h0, 1'b0, LAT + 2, LAT + 1, 32'hCAFE12BB);
    run_req("lhu2", 1'b0, F3_HU, 32'h102, 32'h0, 5'd13, 32'h0000CAFE, 1'b0, LAT + 1, -1, 32'h0);
    run_req("sw",  1'b1, F3_W,  32'h100, 32'hDEADBEEF, 5'd14, 32'h0, 1'b0, 2, 1, 32'hDEADBEEF);
    run_req("lw2", 1'b0, F3_W,  32'h100, 32'h0, 5'd15, 32'hDEADBEEF, 1'b0, LAT + 1, -1, 32'h0);
    run_req("ill_ld", 1'b0, 3'b011, 32'h100, 32'h0, 5'd16, 32'h0, 1'b1, 1, -1, 32'h0);
    run_req("ill_st", 1'b1, 3'b100, 32'h100, 32'h55, 5'd17, 32'h0, 1'b1, 1, -1, 32'h0);

    // Reset during cycle 2 of an SB: nothing may be written or answered.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h101;
    bus.req_wdata  = 32'h55;
    bus.req_rd     = 5'd18;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    check("mid_rst_we", {31'h0, bus.ram_enable_write}, 32'h0);
    check("mid_rst_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_we", {31'h0, bus.ram_enable_write}, 32'h0);
      check("post_rst_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    end
    run_req("lw3", 1'b0, F3_W, 32'h100, 32'h0, 5'd19, 32'hDEADBEEF, 1'b0, LAT + 1, -1, 32'h0);
    check("sb_empty", sb_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the RISC-V `core` execute stage and the word-wide data RAM. It accepts one LOAD/STORE request at a time and returns a completion response. RAM traffic uses 32-bit word accesses only: byte/halfword loads are lane-extracted and extended, and sub-word stores are done as read-modify-write. It owns the `ram_address` / `data_out_ram` / `ram_enable_write` / `data_in_ram` bus.

## Interface
- `RAM_LATENCY`, 1: cycles from `ram_address` valid to `data_in_ram` valid; legal range 1..4.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when both are high.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_rd`  in  5  destination tag, echoed back.
- `rsp_valid`  out  1  one-cycle completion pulse; there is no backpressure.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_rd`  out  5  echoed tag.
- `rsp_err`  out  1  illegal or misaligned request.
- `ram_address`  out  32  word address, `{2'b0, req_addr[31:2]}`.
- `data_in_ram`  in  32  RAM read data.
- `data_out_ram`  out  32  RAM write data.
- `ram_enable_write`  out  1  write strobe, one cycle per write.

## Operation
- States: IDLE, READ (counter 0..RAM_LATENCY-1), WRITE, RESP.
- `req_ready` = (state == IDLE). The request is latched on acceptance.
- Illegal codes:
  - Loads: funct3 011, 110, 111.
  - Stores: funct3 greater than 010.
  - Effect: IDLE→RESP with `rsp_err`=1 and no RAM access.
- Load: IDLE→READ. When the counter reaches its end, `data_in_ram` is sampled, then RESP.
- Load extraction is little-endian:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- SW: IDLE→WRITE. In WRITE, `data_out_ram` = wdata and the strobe is asserted; then RESP.
- SB/SH: IDLE→READ→WRITE, then RESP.
  - The sampled word is merged with wdata[7:0] (SB) or wdata[15:0] (SH) in the addressed lane.
  - Other lanes are preserved.
- RESP → IDLE unconditionally.
- `ram_address` is held stable from the cycle after acceptance through the end of WRITE/READ.

## Timing
- Cycle 0 is the acceptance cycle.
- LW/LB/LH/LBU/LHU: address valid in cycles 1..L; data sampled at the end of cycle L; `rsp_valid` in cycle L+1.
- SW: strobe in cycle 1; `rsp_valid` in cycle 2.
- SB/SH: read in cycles 1..L; strobe in cycle L+1; `rsp_valid` in cycle L+2.
- Error response: `rsp_valid` in cycle 1.
- The next request can be accepted in the cycle after `rsp_valid`. Peak throughput is therefore one request per L+2 cycles for loads.
- Reset values:
  - State IDLE, so `req_ready`=1.
  - All other outputs 0.
- Reset asserted mid-operation:
  - Outputs are cleared asynchronously; `ram_enable_write` drops immediately.
  - The request is discarded and no response is issued.
- `req_valid` while not ready is ignored; the requester must hold it.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned requests (H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0) take the error path.
  - Error path: `rsp_err`=1, `rsp_valid` in cycle 1, no RAM access.
- Undefined:
  - Misalignment is ignored. Halfword uses lane addr[1]; word ignores addr[1:0].
  - The access proceeds normally; `rsp_err` flags only illegal funct3.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum.
  - RAM_LATENCY bounds.
- Sub-module `lsu_align`: purely combinational.
  - Load path: (word, addr[1:0], funct3) → extended result.
  - Store path: (old word, wdata, addr[1:0], funct3) → merged word.
- The FSM, counter and request registers stay in `lsu`.

## Test plan
- The bench uses RAM_LATENCY=2 and a RAM model preloaded with mem[0x40]=0x8899AABB.
- LB at addr 0x103 (word 0x40) → `rsp_valid` in cycle 3, `rsp_rdata`=0xFFFFFF88. The same request as LBU → 0x00000088.
- LHU at 0x102 → 0x00008899. LH at 0x100 → 0xFFFFAABB.
- SB wdata 0x12 at 0x101:
  - Strobe in cycle 3 with `data_out_ram`=0x889912BB; `rsp_valid` in cycle 4.
  - A following LW at 0x100 returns 0x889912BB.
- SW 0xDEADBEEF at 0x100: strobe in cycle 1, `rsp_valid` in cycle 2.
- Errors:
  - funct3=011 load: `rsp_err`=1 in cycle 1, no RAM access.
  - With `LSU_MISALIGN_TRAP_EN`, LW at 0x102: `rsp_err`=1 in cycle 1.
  - Without the macro, LW at 0x102 returns 0x8899AABB with `rsp_err`=0.
- Reset: drop `rst_n` during SB cycle 2 → no strobe, no `rsp_valid`, `req_ready`=1 immediately.
